// File: rtl/player_motion.sv
// Per-player movement: held-key commands become a clamped sprite position once per video frame.
// Latency: state updates on the 3rd Clk edge after frame_clk rises; outputs registered, visible the next cycle.
// Backpressure: none; command is a level sampled only on the frame tick.
module player_motion #(
    parameter logic [9:0] X_INIT      = 10'd100,
    parameter logic [9:0] Y_INIT      = 10'd240,
    parameter logic [9:0] X_MIN       = 10'd0,
    parameter logic [9:0] X_MAX       = 10'd608,
    parameter logic [9:0] Y_MIN       = 10'd0,
    parameter logic [9:0] Y_MAX       = 10'd448,
    parameter logic [2:0] SPEED_MIN   = 3'd1,
    parameter logic [2:0] SPEED_MAX   = 3'd4,
    parameter logic [3:0] RAMP_FRAMES = 4'd8,
    parameter logic [1:0] FACE_INIT   = 2'd3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [3:0] command,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [1:0] facing,
    output logic [2:0] speed,
    output logic       moving
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RAMP   = 2'd1;
    localparam logic [1:0] CRUISE = 2'd2;

    logic              fclk_s1, fclk_s2, fclk_d;
    logic              tick;
    logic [1:0]        state, state_nxt;
    logic [3:0]        cnt, cnt_nxt, cnt_inc;
    logic [2:0]        speed_nxt, speed_inc, step;
    logic signed [1:0] dir_x, dir_y, dir_x_nxt, dir_y_nxt;
    logic signed [1:0] dx, dy;
    logic              net_zero, same_dir, do_move;
    logic [1:0]        facing_nxt;
    logic [9:0]        pos_x_nxt, pos_y_nxt;

    // Opposite keys cancel: unsigned 0-1 wraps to 2'b11, i.e. -1 as signed.
    assign dx        = {1'b0, command[0]} - {1'b0, command[1]};
    assign dy        = {1'b0, command[2]} - {1'b0, command[3]};
    assign net_zero  = (dx == 2'sd0) && (dy == 2'sd0);
    assign same_dir  = (dx == dir_x) && (dy == dir_y);
    assign tick      = fclk_s2 & ~fclk_d;
    assign cnt_inc   = cnt + 4'd1;
    assign speed_inc = speed + 3'd1;
    assign moving    = (state != IDLE);

    // Extra headroom bit so pos + step can never wrap before the clamp.
    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic signed [1:0] d,
                                             input logic [2:0] stp, input logic [9:0] lo,
                                             input logic [9:0] hi);
        logic signed [11:0] p, s, n;
        p = $signed({2'b00, pos});
        s = $signed({9'd0, stp});
        if (d == 2'sd1)
            n = p + s;
        else if (d == -2'sd1)
            n = p - s;
        else
            n = p;
        if (n < $signed({2'b00, lo}))
            return lo;
        else if (n > $signed({2'b00, hi}))
            return hi;
        else
            return n[9:0];
    endfunction

    always_comb begin
        state_nxt = state;
        speed_nxt = speed;
        cnt_nxt   = cnt;
        dir_x_nxt = dir_x;
        dir_y_nxt = dir_y;
        step      = 3'd0;
        do_move   = 1'b0;
        if (net_zero) begin
            state_nxt = IDLE;
            speed_nxt = SPEED_MIN;
            cnt_nxt   = 4'd0;
        end else if (state == IDLE || !same_dir) begin
            do_move   = 1'b1;
            step      = SPEED_MIN;
            speed_nxt = SPEED_MIN;
            cnt_nxt   = 4'd1;
            dir_x_nxt = dx;
            dir_y_nxt = dy;
            state_nxt = (SPEED_MIN == SPEED_MAX) ? CRUISE : RAMP;
        end else if (state == CRUISE) begin
            do_move = 1'b1;
            step    = SPEED_MAX;
        end else begin
            do_move = 1'b1;
            step    = speed;
            if (cnt_inc == RAMP_FRAMES) begin
                cnt_nxt   = 4'd0;
                speed_nxt = speed_inc;
                if (speed_inc == SPEED_MAX)
                    state_nxt = CRUISE;
            end else begin
                cnt_nxt = cnt_inc;
            end
        end
    end

    always_comb begin
        facing_nxt = facing;
        if (dx == -2'sd1)
            facing_nxt = 2'd2;
        else if (dx == 2'sd1)
            facing_nxt = 2'd3;
        else if (dy == -2'sd1)
            facing_nxt = 2'd0;
        else if (dy == 2'sd1)
            facing_nxt = 2'd1;
    end

    assign pos_x_nxt = do_move ? step_axis(pos_x, dx, step, X_MIN, X_MAX) : pos_x;
    assign pos_y_nxt = do_move ? step_axis(pos_y, dy, step, Y_MIN, Y_MAX) : pos_y;

    // Sync flops reset high so a frame_clk already high at release is not seen as an edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fclk_s1 <= 1'b1;
            fclk_s2 <= 1'b1;
            fclk_d  <= 1'b1;
            state   <= IDLE;
            cnt     <= 4'd0;
            speed   <= SPEED_MIN;
            dir_x   <= 2'sd0;
            dir_y   <= 2'sd0;
            pos_x   <= X_INIT;
            pos_y   <= Y_INIT;
            facing  <= FACE_INIT;
        end else begin
            fclk_s1 <= frame_clk;
            fclk_s2 <= fclk_s1;
            fclk_d  <= fclk_s2;
            if (tick) begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                speed  <= speed_nxt;
                dir_x  <= dir_x_nxt;
                dir_y  <= dir_y_nxt;
                pos_x  <= pos_x_nxt;
                pos_y  <= pos_y_nxt;
                facing <= facing_nxt;
            end
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: frame-strobe stimulus with hand-computed positions.
module tb_player_motion;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [3:0] command = 4'b0000;
    logic [9:0] pos_x, pos_y;
    logic [1:0] facing;
    logic [2:0] speed;
    logic       moving;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_RIGHT = 4'b0001;
    localparam logic [3:0] C_LEFT  = 4'b0010;
    localparam logic [3:0] C_LR    = 4'b0011;
    localparam logic [3:0] C_DR    = 4'b0101;
    localparam logic [3:0] C_UP    = 4'b1000;
    localparam logic [3:0] C_UL    = 4'b1010;

    player_motion dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .command   (command),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .facing    (facing),
        .speed     (speed),
        .moving    (moving)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic fclk);
        @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = fclk;
        command   = C_NONE;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    // One full frame: rising strobe, tick lands 3 edges later, then a quiet low phase.
    task automatic do_frame(input logic [3:0] cmd);
        @(negedge Clk);
        command   = cmd;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset released while frame_clk is high: no tick may follow.
        do_reset(1'b1);
        repeat (6) @(negedge Clk);
        check_val("rst_x", pos_x, 100);
        check_val("rst_y", pos_y, 240);
        check_val("rst_face", facing, 3);
        check_val("rst_moving", moving, 0);
        check_val("rst_speed", speed, 1);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        check_val("rst_fall_x", pos_x, 100);

        // Right held 9 frames: +1 x8 then +2.
        do_reset(1'b0);
        do_frame(C_RIGHT);
        check_val("r1_x", pos_x, 101);
        check_val("r1_moving", moving, 1);
        for (int i = 0; i < 7; i++) do_frame(C_RIGHT);
        check_val("r8_x", pos_x, 108);
        check_val("r8_speed", speed, 2);
        do_frame(C_RIGHT);
        check_val("r9_x", pos_x, 110);
        check_val("r9_y", pos_y, 240);
        check_val("r9_speed", speed, 2);
        check_val("r9_moving", moving, 1);
        check_val("r9_face", facing, 3);

        // Left+right cancel.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) do_frame(C_LR);
        check_val("lr_x", pos_x, 100);
        check_val("lr_y", pos_y, 240);
        check_val("lr_moving", moving, 0);
        check_val("lr_face", facing, 3);

        // Walk to x=3 at speed 1 (7 left, 1 idle per group), then clamp at the left wall.
        do_reset(1'b0);
        for (int g = 0; g < 13; g++) begin
            for (int i = 0; i < 7; i++) do_frame(C_LEFT);
            do_frame(C_NONE);
        end
        for (int i = 0; i < 6; i++) do_frame(C_LEFT);
        do_frame(C_NONE);
        check_val("wall_start_x", pos_x, 3);
        check_val("wall_idle", moving, 0);
        do_frame(C_LEFT);
        check_val("wall_x1", pos_x, 2);
        do_frame(C_LEFT);
        check_val("wall_x2", pos_x, 1);
        do_frame(C_LEFT);
        check_val("wall_x3", pos_x, 0);
        do_frame(C_LEFT);
        check_val("wall_x4", pos_x, 0);
        check_val("wall_face", facing, 2);
        check_val("wall_moving", moving, 1);

        // Ramp right to speed 3, then switch to up.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) do_frame(C_RIGHT);
        check_val("sw_pre_x", pos_x, 124);
        check_val("sw_pre_speed", speed, 3);
        do_frame(C_UP);
        check_val("sw_y", pos_y, 239);
        check_val("sw_x", pos_x, 124);
        check_val("sw_speed", speed, 1);
        check_val("sw_face", facing, 0);
        check_val("sw_moving", moving, 1);

        // Diagonals: full step both axes, horizontal wins facing.
        do_reset(1'b0);
        do_frame(C_DR);
        check_val("dr_x", pos_x, 101);
        check_val("dr_y", pos_y, 241);
        check_val("dr_face", facing, 3);
        do_frame(C_UL);
        check_val("ul_x", pos_x, 100);
        check_val("ul_y", pos_y, 240);
        check_val("ul_face", facing, 2);
        do_frame(C_NONE);
        check_val("ul_hold_face", facing, 2);
        check_val("ul_idle", moving, 0);

        // Reset between frame_clk rise and tick discards the pending tick.
        do_reset(1'b0);
        do_frame(C_UP);
        check_val("mid_pre_y", pos_y, 239);
        @(negedge Clk);
        command   = C_UP;
        frame_clk = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        check_val("mid_x", pos_x, 100);
        check_val("mid_y", pos_y, 240);
        check_val("mid_face", facing, 3);
        check_val("mid_speed", speed, 1);
        check_val("mid_moving", moving, 0);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
